// File: rtl/uart_pwm_pkg.sv
// Shared constants and types for the UART command parser feeding the PWM core.
// Optional macro UART_CMD_LOWERCASE_EN is consumed by uart_cmd_parser, not here.
package uart_pwm_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_D    = 8'h44;
    localparam logic [7:0] ASCII_F    = 8'h46;
    localparam logic [7:0] ASCII_D_LC = 8'h64;
    localparam logic [7:0] ASCII_F_LC = 8'h66;

    localparam int unsigned DUTY_MAX = 100;

    typedef enum logic [1:0] {
        S_CMD,
        S_NUM,
        S_COMMIT,
        S_DISCARD
    } parser_state_t;

    typedef enum logic {
        TGT_DUTY,
        TGT_FREQ
    } target_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_dec_accum.sv
// Registered decimal accumulator: value = value*10 + digit per strobe,
// with a digit counter and a sticky flag once value no longer fits LIM_W bits.
module dec_accum
    import uart_pwm_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned LIM_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [ACC_W-1:0] next_value;

    always_comb begin
        next_value = value * ACC_W'(10) + ACC_W'(digit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (digit_valid) begin
            value <= next_value;
            count <= count + CNT_W'(1);
            if (|next_value[ACC_W-1:LIM_W]) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses CR-terminated "D<n>" / "F<n>" commands from the RX FIFO into PWM config.
// Macro UART_CMD_LOWERCASE_EN: also accept 'd' and 'f' as command letters.
module uart_cmd_parser
    import uart_pwm_pkg::*;
#(
    parameter int unsigned FREQ_W     = 20,
    parameter int unsigned FREQ_MIN   = 1,
    parameter int unsigned FREQ_MAX   = 1_000_000,
    parameter int unsigned MAX_DIGITS = 7,
    parameter int unsigned DUTY_RST   = 50,
    parameter int unsigned FREQ_RST   = 1000
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic [7:0]        fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_read,
    output logic [6:0]        duty_pct,
    output logic [FREQ_W-1:0] freq_hz,
    output logic              cfg_update,
    output logic              cmd_error,
    output logic              busy
);

    localparam int unsigned ACC_W = FREQ_W + 4;
    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    parser_state_t     state_q, state_d;
    target_t           tgt_q, tgt_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic [6:0]        duty_d;
    logic [FREQ_W-1:0] freq_d;
    logic              upd_d, err_d;

    logic              acc_clear, acc_digit;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              is_duty, is_freq, cmd_ok;

    dec_accum #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W),
        .LIM_W (FREQ_W)
    ) u_accum (
        .clk         (clk_50mhz),
        .rst         (rst),
        .clear       (acc_clear),
        .digit_valid (acc_digit),
        // is_digit() guarantees the high nibble is 3, so the low nibble is the value
        .digit       (byte_q[3:0]),
        .value       (acc),
        .count       (cnt),
        .ovf         (ovf)
    );

`ifdef UART_CMD_LOWERCASE_EN
    assign is_duty = (byte_q == ASCII_D) || (byte_q == ASCII_D_LC);
    assign is_freq = (byte_q == ASCII_F) || (byte_q == ASCII_F_LC);
`else
    assign is_duty = (byte_q == ASCII_D);
    assign is_freq = (byte_q == ASCII_F);
`endif

    always_comb begin
        cmd_ok = (cnt != '0) && !ovf;
        if (tgt_q == TGT_DUTY) begin
            cmd_ok = cmd_ok && (acc <= ACC_W'(DUTY_MAX));
        end else begin
            cmd_ok = cmd_ok && (acc >= ACC_W'(FREQ_MIN)) && (acc <= ACC_W'(FREQ_MAX));
        end
    end

    assign busy = (state_q != S_CMD);

    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        byte_d       = byte_q;
        byte_valid_d = byte_valid_q;
        duty_d       = duty_pct;
        freq_d       = freq_hz;
        upd_d        = 1'b0;
        err_d        = 1'b0;
        fifo_read    = 1'b0;
        acc_clear    = 1'b0;
        acc_digit    = 1'b0;

        if (state_q == S_COMMIT) begin
            if (cmd_ok) begin
                upd_d = 1'b1;
                if (tgt_q == TGT_DUTY) begin
                    duty_d = acc[6:0];
                end else begin
                    freq_d = acc[FREQ_W-1:0];
                end
            end else begin
                err_d = 1'b1;
            end
            state_d = S_CMD;
        end else if (!byte_valid_q) begin
            // fetch phase; gated by rst so no pop strobe escapes while reset is held
            if (!fifo_empty && !rst) begin
                fifo_read    = 1'b1;
                byte_d       = fifo_data;
                byte_valid_d = 1'b1;
            end
        end else begin
            byte_valid_d = 1'b0;
            unique case (state_q)
                S_CMD: begin
                    if (is_duty) begin
                        tgt_d     = TGT_DUTY;
                        acc_clear = 1'b1;
                        state_d   = S_NUM;
                    end else if (is_freq) begin
                        tgt_d     = TGT_FREQ;
                        acc_clear = 1'b1;
                        state_d   = S_NUM;
                    end else if ((byte_q != ASCII_CR) && (byte_q != ASCII_LF)) begin
                        state_d = S_DISCARD;
                    end
                end
                S_NUM: begin
                    if (is_digit(byte_q)) begin
                        if (cnt == CNT_W'(MAX_DIGITS)) begin
                            state_d = S_DISCARD;
                        end else begin
                            acc_digit = 1'b1;
                        end
                    end else if (byte_q == ASCII_CR) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (byte_q == ASCII_CR) begin
                        err_d   = 1'b1;
                        state_d = S_CMD;
                    end
                end
                default: state_d = S_CMD;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q      <= S_CMD;
            tgt_q        <= TGT_DUTY;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            duty_pct     <= 7'(DUTY_RST);
            freq_hz      <= FREQ_W'(FREQ_RST);
            cfg_update   <= 1'b0;
            cmd_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            duty_pct     <= duty_d;
            freq_hz      <= freq_d;
            cfg_update   <= upd_d;
            cmd_error    <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser driven through a modelled RX FIFO.
module tb_uart_cmd_parser;

    logic        clk_50mhz = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic [6:0]  duty_pct;
    logic [19:0] freq_hz;
    logic        cfg_update;
    logic        cmd_error;
    logic        busy;

    logic [7:0] fifo_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int upd_total = 0, err_total = 0, both_total = 0, badread_total = 0;
    int upd_mark, err_mark;

    always #10 clk_50mhz = ~clk_50mhz;

    assign fifo_empty = (fifo_q.size() == 0);
    assign fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];

    uart_cmd_parser #(
        .FREQ_W     (20),
        .FREQ_MIN   (1),
        .FREQ_MAX   (1_000_000),
        .MAX_DIGITS (7),
        .DUTY_RST   (50),
        .FREQ_RST   (1000)
    ) dut (
        .clk_50mhz  (clk_50mhz),
        .rst        (rst),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .duty_pct   (duty_pct),
        .freq_hz    (freq_hz),
        .cfg_update (cfg_update),
        .cmd_error  (cmd_error),
        .busy       (busy)
    );

    always @(posedge clk_50mhz) begin
        if (fifo_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
    end

    always @(negedge clk_50mhz) begin
        if (cfg_update) upd_total++;
        if (cmd_error) err_total++;
        if (cfg_update && cmd_error) both_total++;
        if (fifo_read && fifo_empty) badread_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    // Push body + CR, then allow two cycles per byte plus margin for the pulse.
    task automatic send(input string body, input bit add_cr);
        int n;
        n = body.len() + (add_cr ? 1 : 0);
        upd_mark = upd_total;
        err_mark = err_total;
        for (int i = 0; i < body.len(); i++) push_byte(body[i]);
        if (add_cr) push_byte(8'h0D);
        repeat (2 * n + 6) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
    endtask

    task automatic expect_cmd(input string tag, input int upd, input int err,
                              input int duty, input int freq);
        check({tag, " upd"}, 32'(upd_total - upd_mark), 32'(upd));
        check({tag, " err"}, 32'(err_total - err_mark), 32'(err));
        check({tag, " duty"}, 32'(duty_pct), 32'(duty));
        check({tag, " freq"}, 32'(freq_hz), 32'(freq));
        check({tag, " drained"}, 32'(fifo_q.size()), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        check("rst duty", 32'(duty_pct), 32'd50);
        check("rst freq", 32'(freq_hz), 32'd1000);
        check("rst busy", 32'(busy), 32'd0);
        check("rst upd", 32'(cfg_update), 32'd0);
        check("rst err", 32'(cmd_error), 32'd0);
        check("rst read", 32'(fifo_read), 32'd0);

        send("D75", 1'b1);       expect_cmd("D75", 1, 0, 75, 1000);
        send("F20000", 1'b1);    expect_cmd("F20000", 1, 0, 75, 20000);
        send("D0", 1'b1);        expect_cmd("D0", 1, 0, 0, 20000);
        send("D101", 1'b1);      expect_cmd("D101", 0, 1, 0, 20000);
        send("F0", 1'b1);        expect_cmd("F0", 0, 1, 0, 20000);
        send("X5", 1'b1);        expect_cmd("X5", 0, 1, 0, 20000);
        send("D10", 1'b1);       expect_cmd("D10", 1, 0, 10, 20000);
        send("F12345678", 1'b1); expect_cmd("F8dig", 0, 1, 10, 20000);
        send("D", 1'b1);         expect_cmd("Dempty", 0, 1, 10, 20000);
        send("D100", 1'b1);      expect_cmd("D100", 1, 0, 100, 20000);
        send("F1000001", 1'b1);  expect_cmd("Fmax+1", 0, 1, 100, 20000);
        send("F1234567", 1'b1);  expect_cmd("F7dig", 0, 1, 100, 20000);
        send("F1000000", 1'b1);  expect_cmd("Fmax", 1, 0, 100, 1000000);
        send("F1", 1'b1);        expect_cmd("Fmin", 1, 0, 100, 1);
        send("D5x", 1'b1);       expect_cmd("D5x", 0, 1, 100, 1);

        upd_mark = upd_total;
        err_mark = err_total;
        push_byte(8'h0D);
        push_byte(8'h0A);
        repeat (10) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        expect_cmd("blank", 0, 0, 100, 1);

        send("d42", 1'b1);
`ifdef UART_CMD_LOWERCASE_EN
        expect_cmd("lower", 1, 0, 42, 1);
`else
        expect_cmd("lower", 0, 1, 100, 1);
`endif
        send("D60", 1'b1);       expect_cmd("D60", 1, 0, 60, 1);

        send("F99", 1'b0);
        check("partial busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        check("midrst busy", 32'(busy), 32'd0);
        expect_cmd("midrst", 0, 0, 50, 1000);
        send("9", 1'b1);         expect_cmd("trail9", 0, 1, 50, 1000);

        check("busy end", 32'(busy), 32'd0);
        check("both pulses", 32'(both_total), 32'd0);
        check("read on empty", 32'(badread_total), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Consumes bytes from the uart_rx receive FIFO.
- Parses CR-terminated ASCII commands and drives the PWM generator's configuration registers: duty cycle in percent and frequency in Hz.
- Sits directly downstream of uart_rx and upstream of the PWM core.
- Bad commands are discarded, reported with an error pulse, and leave the previous configuration intact.

Parameters:
- FREQ_W, 20: width of freq_hz.
- FREQ_MIN, 1: smallest accepted frequency in Hz.
- FREQ_MAX, 1_000_000: largest accepted frequency in Hz.
- MAX_DIGITS, 7: maximum decimal digits per argument.
- DUTY_RST, 50: reset value of duty_pct.
- FREQ_RST, 1000: reset value of freq_hz.

Ports:
- clk_50mhz  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_data  in  8  show-ahead head of the RX FIFO; valid whenever fifo_empty=0.
- fifo_empty  in  1  RX FIFO has no data.
- fifo_read  out  1  one-cycle pop strobe; FIFO advances on the next edge.
- duty_pct  out  7  active duty cycle, 0..100.
- freq_hz  out  FREQ_W  active PWM frequency.
- cfg_update  out  1  one-cycle pulse when duty_pct or freq_hz is updated.
- cmd_error  out  1  one-cycle pulse when a command is rejected.
- busy  out  1  high while a command is partially received (state != S_CMD).

Behaviour:
- Reset values: fifo_read=0, cfg_update=0, cmd_error=0, busy=0, duty_pct=DUTY_RST, freq_hz=FREQ_RST, state=S_CMD, accumulator=0, digit count=0.
- Fetch:
  - In a fetch cycle with fifo_empty=0, assert fifo_read for exactly one cycle and register fifo_data into byte_q.
  - The following cycle processes byte_q with fifo_read=0.
  - Maximum throughput is one byte per 2 cycles.
  - When fifo_empty=1: no read, state holds.
- Grammar: cmd = ('D' | 'F') digit{1..MAX_DIGITS} CR. CR=0x0D. LF=0x0A is ignored in S_CMD only.
- S_CMD:
  - 'D' -> S_NUM with target=DUTY; 'F' -> S_NUM with target=FREQ. Both clear the accumulator and digit count.
  - CR or LF -> stay, no pulse (blank line).
  - Any other byte -> S_DISCARD.
- S_NUM:
  - Digit '0'..'9' -> acc = acc*10 + (byte-0x30), cnt++.
  - If cnt would exceed MAX_DIGITS -> S_DISCARD.
  - CR -> S_COMMIT.
  - Any other byte -> S_DISCARD.
- Accumulator:
  - Width is FREQ_W+4 bits so that MAX_DIGITS digits cannot wrap.
  - Set a sticky ovf bit if acc exceeds 2**FREQ_W-1.
- S_COMMIT (1 cycle):
  - Valid when cnt>=1 and ovf=0, and the range check passes: DUTY requires acc<=100; FREQ requires FREQ_MIN<=acc<=FREQ_MAX.
  - If valid: load the target register, pulse cfg_update in this cycle; the new value is visible on the same edge as the pulse.
  - Otherwise: pulse cmd_error; registers unchanged.
  - Always return to S_CMD.
- S_DISCARD: consume bytes until CR, then pulse cmd_error in the cycle after the CR is processed and return to S_CMD. Exactly one error pulse per bad command.
- cfg_update and cmd_error are never high in the same cycle.
- Reset mid-command: partial command is dropped, outputs return to reset values, no pulse is issued.
- FIFO running empty mid-command: parser waits indefinitely; there is no timeout.

Optional Feature:
- Macro: UART_CMD_LOWERCASE_EN.
- Defined: 'd' and 'f' are accepted as equivalents of 'D' and 'F'.
- Undefined: lowercase letters are invalid and lead to S_DISCARD plus cmd_error.

Decomposition:
- Package uart_pwm_pkg holds:
  - ASCII constants (ASCII_CR, ASCII_LF, ASCII_0, ASCII_D, ASCII_F).
  - The parser state enum (S_CMD, S_NUM, S_COMMIT, S_DISCARD).
  - The target enum (TGT_DUTY, TGT_FREQ).
  - DUTY_MAX=100.
- One sub-module, dec_accum: registered decimal accumulator.
  - Inputs: clear, digit-valid strobe, 4-bit digit.
  - Outputs: value, digit count, sticky overflow.

Test Plan:
- "D75\r" -> duty_pct=75, a single cfg_update pulse, cmd_error never asserted, freq_hz stays 1000.
- "F20000\r" then "D0\r" -> freq_hz=20000, then duty_pct=0; two cfg_update pulses.
- "D101\r" and "F0\r" -> one cmd_error pulse each; duty_pct and freq_hz keep their prior values.
- "X5\r" then "D10\r" -> one cmd_error, then duty_pct=10 with cfg_update.
- "F12345678\r" (8 digits) and "D\r" -> one cmd_error each. Blank "\r\n" -> no pulse.
- Mid-command reset:
  - Send "F99", assert rst for 3 cycles, then send "9\r".
  - Required: freq_hz=1000 and duty_pct=50 after reset; the trailing "9\r" produces cmd_error.
  - fifo_read is never asserted while fifo_empty=1.
